// File: rtl/bus_decoder.sv
// bus_decoder: routes picorv32 native memory requests to one of NUM_SLAVES
// address windows, muxes the response back, and turns unmapped, illegal or
// stalled accesses into an error response so the CPU never hangs.
module bus_decoder #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h10000100, 32'h10000000, 32'h00001000, 32'h00000000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFF000, 32'hFFFFF000},
    parameter logic [NUM_SLAVES-1:0] SLAVE_INSTR_OK = 4'b0001,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                             clk_in,
    input  logic                             reset_n_in,
    input  logic                             m_valid_in,
    input  logic                             m_instr_in,
    input  logic [ADDR_WIDTH-1:0]            m_addr_in,
    input  logic [DATA_WIDTH-1:0]            m_wdata_in,
    input  logic [DATA_WIDTH/8-1:0]          m_wstrb_in,
    output logic                             m_ready_out,
    output logic [DATA_WIDTH-1:0]            m_rdata_out,
    output logic [NUM_SLAVES-1:0]            s_enable_out,
    output logic                             s_write_out,
    output logic [ADDR_WIDTH-1:0]            s_addr_out,
    output logic [DATA_WIDTH-1:0]            s_wdata_out,
    output logic [DATA_WIDTH/8-1:0]          s_wstrb_out,
    input  logic [NUM_SLAVES-1:0]            s_ready_in,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_in,
    output logic                             err_out,
    output logic [ADDR_WIDTH-1:0]            err_addr_out,
    output logic [7:0]                       err_count_out
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SEL_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TMO_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e                  state_q, state_d;

    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   enable_q, enable_d;
    logic [ADDR_WIDTH-1:0]   s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]   s_wdata_q, s_wdata_d;
    logic [STRB_WIDTH-1:0]   s_wstrb_q, s_wstrb_d;
    logic                    s_write_q, s_write_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    req_wr_q, req_wr_d;
    logic                    err_pend_q, err_pend_d;
    logic [TMO_WIDTH-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic                    dec_hit;
    logic [SEL_WIDTH-1:0]    dec_idx;
    logic [ADDR_WIDTH-1:0]   dec_mask;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    tmo_hit;

    // Address decode: lowest-index window that hits and permits this access type
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_mask = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit &&
                ((m_addr_in & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (!m_instr_in || SLAVE_INSTR_OK[i])) begin
                dec_hit  = 1'b1;
                dec_idx  = SEL_WIDTH'(i);
                dec_mask = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Response mux: only the selected slave's ready and data are observed
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_WIDTH'(i)) begin
                sel_ready = s_ready_in[i];
                sel_rdata = s_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Timeout fires when the ACTIVE cycle counter has reached TIMEOUT
    always_comb begin
        tmo_hit = 1'b0;
        if (TIMEOUT != 0) begin
            tmo_hit = (tmo_cnt_q == TMO_WIDTH'(TIMEOUT));
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; decode misses spend one cycle in ACTIVE with no slave
    // enabled so the error response lands on the same edge as the fastest slave
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m_valid_in) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!m_valid_in) begin
                    state_d = ST_IDLE;
                end else if (err_pend_q || sel_ready || tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: latch the request, drive the slave, form the response
    always_comb begin
        sel_d      = sel_q;
        enable_d   = enable_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        s_write_d  = s_write_q;
        req_addr_d = req_addr_q;
        req_wr_d   = req_wr_q;
        err_pend_d = err_pend_q;
        tmo_cnt_d  = tmo_cnt_q;
        ready_d    = 1'b0;
        rdata_d    = '0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (m_valid_in) begin
                    req_addr_d = m_addr_in;
                    req_wr_d   = |m_wstrb_in;
                    err_pend_d = !dec_hit;
                    tmo_cnt_d  = '0;
                    if (dec_hit) begin
                        sel_d             = dec_idx;
                        enable_d          = '0;
                        enable_d[dec_idx] = 1'b1;
                        s_addr_d          = m_addr_in & ~dec_mask;
                        s_wdata_d         = m_wdata_in;
                        s_wstrb_d         = m_wstrb_in;
                        s_write_d         = |m_wstrb_in;
                    end
                end
            end
            ST_ACTIVE: begin
                tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
                if (!m_valid_in) begin
                    enable_d = '0;
                end else if (!err_pend_q && sel_ready) begin
                    enable_d = '0;
                    ready_d  = 1'b1;
                    rdata_d  = req_wr_q ? '0 : sel_rdata;
                end else if (err_pend_q || tmo_hit) begin
                    enable_d   = '0;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = req_wr_q ? '0 : ERR_DATA;
                    err_addr_d = req_addr_q;
                    err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                enable_d = '0;
            end
            default: begin
                enable_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sel_q      <= '0;
            enable_q   <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            s_write_q  <= 1'b0;
            req_addr_q <= '0;
            req_wr_q   <= 1'b0;
            err_pend_q <= 1'b0;
            tmo_cnt_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            sel_q      <= sel_d;
            enable_q   <= enable_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            s_write_q  <= s_write_d;
            req_addr_q <= req_addr_d;
            req_wr_q   <= req_wr_d;
            err_pend_q <= err_pend_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m_ready_out   = ready_q;
    assign m_rdata_out   = rdata_q;
    assign s_enable_out  = enable_q;
    assign s_write_out   = s_write_q;
    assign s_addr_out    = s_addr_q;
    assign s_wdata_out   = s_wdata_q;
    assign s_wstrb_out   = s_wstrb_q;
    assign err_out       = err_q;
    assign err_addr_out  = err_addr_q;
    assign err_count_out = err_cnt_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: expected responses are queued when a request
// is issued and compared when m_ready_out pulses.
module tb_bus_decoder;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk_in = 1'b0;
    logic            reset_n_in = 1'b0;
    logic            m_valid_in = 1'b0;
    logic            m_instr_in = 1'b0;
    logic [AW-1:0]   m_addr_in = '0;
    logic [DW-1:0]   m_wdata_in = '0;
    logic [DW/8-1:0] m_wstrb_in = '0;
    logic            m_ready_out;
    logic [DW-1:0]   m_rdata_out;
    logic [NS-1:0]   s_enable_out;
    logic            s_write_out;
    logic [AW-1:0]   s_addr_out;
    logic [DW-1:0]   s_wdata_out;
    logic [DW/8-1:0] s_wstrb_out;
    logic [NS-1:0]   s_ready_in = '0;
    logic [NS*DW-1:0] s_rdata_in = '0;
    logic            err_out;
    logic [AW-1:0]   err_addr_out;
    logic [7:0]      err_count_out;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    bus_decoder dut (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .m_valid_in    (m_valid_in),
        .m_instr_in    (m_instr_in),
        .m_addr_in     (m_addr_in),
        .m_wdata_in    (m_wdata_in),
        .m_wstrb_in    (m_wstrb_in),
        .m_ready_out   (m_ready_out),
        .m_rdata_out   (m_rdata_out),
        .s_enable_out  (s_enable_out),
        .s_write_out   (s_write_out),
        .s_addr_out    (s_addr_out),
        .s_wdata_out   (s_wdata_out),
        .s_wstrb_out   (s_wstrb_out),
        .s_ready_in    (s_ready_in),
        .s_rdata_in    (s_rdata_in),
        .err_out       (err_out),
        .err_addr_out  (err_addr_out),
        .err_count_out (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Hard stop in case a bounded wait itself is broken
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
        m_valid_in = 1'b1;
        m_instr_in = instr;
        m_addr_in  = addr;
        m_wdata_in = wdata;
        m_wstrb_in = wstrb;
    endtask

    task automatic idle_bus();
        m_valid_in = 1'b0;
        m_instr_in = 1'b0;
        m_wstrb_in = '0;
        s_ready_in = '0;
    endtask

    task automatic set_slave(input int idx, input logic [31:0] d);
        s_ready_in = NS'(1) << idx;
        s_rdata_in[idx*DW +: DW] = d;
    endtask

    task automatic push(input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        q.push_back(e);
    endtask

    // Wait (bounded) for the response strobe, then score it against the queue
    task automatic resp(input string tag, input int max_cyc, output int lat, output int en_cyc);
        exp_t e;
        logic got;
        lat = 0;
        en_cyc = 0;
        got = 1'b0;
        while (!got && lat < max_cyc) begin
            @(negedge clk_in);
            lat++;
            if (m_ready_out === 1'b1) got = 1'b1;
            else if (s_enable_out !== '0) en_cyc++;
        end
        chk({tag, "_ready_seen"}, 64'(got), 64'd1);
        if (got) begin
            e = q.pop_front();
            chk({tag, "_rdata"}, 64'(m_rdata_out), 64'(e.rdata));
            chk({tag, "_err"}, 64'(err_out), 64'(e.err));
            if (e.err && exp_cnt < 255) exp_cnt++;
            chk({tag, "_err_count"}, 64'(err_count_out), 64'(exp_cnt));
        end
    endtask

    // Response must be a single-cycle strobe with data returning to zero
    task automatic after_resp(input string tag);
        idle_bus();
        @(negedge clk_in);
        chk({tag, "_ready_pulse"}, 64'(m_ready_out), 64'd0);
        chk({tag, "_rdata_idle"}, 64'(m_rdata_out), 64'd0);
        chk({tag, "_err_pulse"}, 64'(err_out), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_ready"}, 64'(m_ready_out), 64'd0);
        chk({tag, "_m_rdata"}, 64'(m_rdata_out), 64'd0);
        chk({tag, "_s_enable"}, 64'(s_enable_out), 64'd0);
        chk({tag, "_s_write"}, 64'(s_write_out), 64'd0);
        chk({tag, "_s_addr"}, 64'(s_addr_out), 64'd0);
        chk({tag, "_s_wdata"}, 64'(s_wdata_out), 64'd0);
        chk({tag, "_s_wstrb"}, 64'(s_wstrb_out), 64'd0);
        chk({tag, "_err"}, 64'(err_out), 64'd0);
        chk({tag, "_err_addr"}, 64'(err_addr_out), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count_out), 64'd0);
    endtask

    initial begin
        int lat;
        int en_cyc;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        reset_n_in = 1'b1;
        @(negedge clk_in);

        // ROM fetch, slave ready one cycle after enable
        req(1'b1, 32'h0000_0010, 32'h0, 4'b0000);
        push(32'h1234_5678, 1'b0);
        @(negedge clk_in);
        chk("rom_enable", 64'(s_enable_out), 64'h1);
        chk("rom_s_addr", 64'(s_addr_out), 64'h10);
        chk("rom_s_write", 64'(s_write_out), 64'd0);
        chk("rom_no_err", 64'(err_out), 64'd0);
        set_slave(0, 32'h1234_5678);
        resp("rom", 8, lat, en_cyc);
        chk("rom_latency", 64'(lat + 1), 64'd2);
        chk("rom_enable_dropped", 64'(s_enable_out), 64'd0);
        after_resp("rom");

        // RAM write; a non-selected ready is ignored
        req(1'b0, 32'h0000_1FFC, 32'hCAFE_F00D, 4'b0011);
        push(32'h0, 1'b0);
        @(negedge clk_in);
        chk("ram_enable", 64'(s_enable_out), 64'h2);
        chk("ram_s_write", 64'(s_write_out), 64'd1);
        chk("ram_s_addr", 64'(s_addr_out), 64'hFFC);
        chk("ram_s_wstrb", 64'(s_wstrb_out), 64'h3);
        chk("ram_s_wdata", 64'(s_wdata_out), 64'hCAFE_F00D);
        set_slave(0, 32'h1111_1111);
        @(negedge clk_in);
        chk("ram_other_ready_ignored", 64'(m_ready_out), 64'd0);
        chk("ram_enable_held", 64'(s_enable_out), 64'h2);
        set_slave(1, 32'hFFFF_FFFF);
        resp("ram_wr", 8, lat, en_cyc);
        after_resp("ram_wr");

        // Instruction fetch from a data-only window
        req(1'b1, 32'h0000_1000, 32'h0, 4'b0000);
        push(32'hDEAD_BEEF, 1'b1);
        resp("ill_fetch", 8, lat, en_cyc);
        chk("ill_fetch_latency", 64'(lat), 64'd2);
        chk("ill_fetch_no_enable", 64'(en_cyc), 64'd0);
        chk("ill_fetch_err_addr", 64'(err_addr_out), 64'h0000_1000);
        after_resp("ill_fetch");

        // Last byte of an IO window
        req(1'b0, 32'h1000_00FC, 32'h0, 4'b0000);
        push(32'h600D_CAFE, 1'b0);
        @(negedge clk_in);
        chk("io_edge_enable", 64'(s_enable_out), 64'h4);
        chk("io_edge_s_addr", 64'(s_addr_out), 64'hFC);
        set_slave(2, 32'h600D_CAFE);
        resp("io_edge", 8, lat, en_cyc);
        after_resp("io_edge");

        // CPU drops valid mid-transaction: no response, no error
        req(1'b0, 32'h0000_1004, 32'h0, 4'b0000);
        @(negedge clk_in);
        chk("abort_enable", 64'(s_enable_out), 64'h2);
        idle_bus();
        @(negedge clk_in);
        chk("abort_enable_dropped", 64'(s_enable_out), 64'd0);
        chk("abort_no_ready", 64'(m_ready_out), 64'd0);
        @(negedge clk_in);
        chk("abort_no_ready2", 64'(m_ready_out), 64'd0);
        chk("abort_err_count", 64'(err_count_out), 64'(exp_cnt));

        // Unmapped reads until the error counter saturates
        for (int n = 0; n < 300; n++) begin
            req(1'b0, 32'h2000_0000, 32'h0, 4'b0000);
            push(32'hDEAD_BEEF, 1'b1);
            resp("unmapped", 8, lat, en_cyc);
            after_resp("unmapped");
        end
        chk("unmapped_saturated", 64'(err_count_out), 64'd255);
        chk("unmapped_err_addr", 64'(err_addr_out), 64'h2000_0000);

        // Slave never answers: forced error after the timeout
        req(1'b0, 32'h1000_0104, 32'h0, 4'b0000);
        push(32'hDEAD_BEEF, 1'b1);
        resp("timeout", 400, lat, en_cyc);
        chk("timeout_enable_cycles", 64'(en_cyc), 64'd256);
        chk("timeout_err_addr", 64'(err_addr_out), 64'h1000_0104);
        chk("timeout_s_addr_held", 64'(s_addr_out), 64'h4);
        after_resp("timeout");

        // Ready on the timeout edge wins
        req(1'b0, 32'h1000_0104, 32'h0, 4'b0000);
        push(32'hA5A5_A5A5, 1'b0);
        repeat (256) @(negedge clk_in);
        chk("race_enable_held", 64'(s_enable_out), 64'h8);
        chk("race_no_ready_yet", 64'(m_ready_out), 64'd0);
        set_slave(3, 32'hA5A5_A5A5);
        resp("race", 4, lat, en_cyc);
        chk("race_latency", 64'(lat), 64'd1);
        after_resp("race");

        // Asynchronous reset while a slave is enabled
        req(1'b0, 32'h1000_0010, 32'h0, 4'b0000);
        @(negedge clk_in);
        chk("rst_mid_enable", 64'(s_enable_out), 64'h4);
        #2;
        reset_n_in = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_cnt = 0;
        idle_bus();
        @(negedge clk_in);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        // First request after reset release decodes normally
        req(1'b0, 32'h0000_0020, 32'h0, 4'b0000);
        push(32'h55AA_33CC, 1'b0);
        @(negedge clk_in);
        chk("post_rst_enable", 64'(s_enable_out), 64'h1);
        chk("post_rst_s_addr", 64'(s_addr_out), 64'h20);
        set_slave(0, 32'h55AA_33CC);
        resp("post_rst", 8, lat, en_cyc);
        after_resp("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
